// File: rtl/perf_pkg.sv
// Shared register map and bus state encoding for the Wishbone performance
// monitor and its per-channel counter slices.
package perf_pkg;

   localparam logic [11:0] OFF_CTRL   = 12'h000;
   localparam logic [11:0] OFF_STATUS = 12'h004;
   localparam logic [11:0] OFF_ID     = 12'h008;

   // Channel windows live in the 0x100 page, one stride per channel.
   localparam logic [3:0]  CHAN_PAGE     = 4'h1;
   localparam int          CHAN_STRIDE   = 'h10;
   localparam int          CHAN_IDX_LSB  = $clog2(CHAN_STRIDE);

   localparam logic [3:0]  CH_TIME    = 4'h0;
   localparam logic [3:0]  CH_ACK     = 4'h4;
   localparam logic [3:0]  CH_MAXLAT  = 4'h8;
   localparam logic [3:0]  CH_LASTLAT = 4'hC;

   localparam int          CTRL_CLR_BIT = 31;
   localparam logic [7:0]  ID_MAGIC     = 8'h50;

   typedef enum logic {S_IDLE, S_ACK} bus_state_e;

endpackage

// File: rtl/perf_chan.sv
// One monitored master: access-time, ack and latency counters with
// saturation, bus write-load and a global clear.
module perf_chan
   import perf_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int LAT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             m_cyc_i,
   input  logic             m_stb_i,
   input  logic             m_ack_i,
   input  logic             wr_time_i,
   input  logic             wr_ack_i,
   input  logic             wr_maxlat_i,
   input  logic [31:0]      wdat_i,
   output logic [CNT_W-1:0] time_o,
   output logic [CNT_W-1:0] ack_o,
   output logic [LAT_W-1:0] maxlat_o,
   output logic [LAT_W-1:0] lastlat_o,
   output logic             ovf_set_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [LAT_W-1:0] LAT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [LAT_W-1:0] sat_inc_lat(input logic [LAT_W-1:0] v);
      return (v == LAT_MAX) ? v : v + LAT_W'(1);
   endfunction

   logic [CNT_W-1:0] time_q, time_d, ack_q, ack_d;
   logic [LAT_W-1:0] maxlat_q, maxlat_d, lastlat_q, lastlat_d, cur_q, cur_d;
   logic             busy, done, hit_ack;
   logic [LAT_W-1:0] lat_new;
   logic             unused_wdat;

   assign busy        = m_cyc_i & m_stb_i;
   assign done        = busy & m_ack_i;
   assign hit_ack     = m_cyc_i & m_ack_i;
   assign lat_new     = sat_inc_lat(cur_q);
   assign unused_wdat = ^wdat_i;

   // cur at all-ones while busy means either cur or cur+1 is clipping.
   assign ovf_set_o = en_i & ~clr_i &
                      ((busy & ~wr_time_i & (time_q == CNT_MAX)) |
                       (hit_ack & ~wr_ack_i & (ack_q == CNT_MAX)) |
                       (busy & (cur_q == LAT_MAX)));

   always_comb begin
      time_d    = time_q;
      ack_d     = ack_q;
      maxlat_d  = maxlat_q;
      lastlat_d = lastlat_q;
      cur_d     = cur_q;
      if (clr_i) begin
         time_d    = '0;
         ack_d     = '0;
         maxlat_d  = '0;
         lastlat_d = '0;
         cur_d     = '0;
      end else begin
         if (en_i) begin
            if (busy)    time_d = sat_inc_cnt(time_q);
            if (hit_ack) ack_d  = sat_inc_cnt(ack_q);
            if (done) begin
               lastlat_d = lat_new;
               if (lat_new > maxlat_q) maxlat_d = lat_new;
               cur_d = '0;
            end else if (busy) begin
               cur_d = lat_new;
            end else if (!m_cyc_i) begin
               cur_d = '0;
            end
         end
         if (wr_time_i)   time_d   = wdat_i[CNT_W-1:0];
         if (wr_ack_i)    ack_d    = wdat_i[CNT_W-1:0];
         if (wr_maxlat_i) maxlat_d = wdat_i[LAT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         time_q    <= '0;
         ack_q     <= '0;
         maxlat_q  <= '0;
         lastlat_q <= '0;
         cur_q     <= '0;
      end else begin
         time_q    <= time_d;
         ack_q     <= ack_d;
         maxlat_q  <= maxlat_d;
         lastlat_q <= lastlat_d;
         cur_q     <= cur_d;
      end
   end

   assign time_o    = time_q;
   assign ack_o     = ack_q;
   assign maxlat_o  = maxlat_q;
   assign lastlat_o = lastlat_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Wishbone slave exposing per-master performance counters: bus FSM,
// address decode, CTRL/STATUS registers and the read-back mux.
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = 32,
   parameter int LAT_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     wb_adr,
   input  logic [31:0]     wb_dat_o,
   output logic [31:0]     wb_dat_i,
   input  logic            wb_we,
   input  logic            wb_stb,
   input  logic            wb_cyc,
   input  logic [3:0]      wb_sel,
   output logic            wb_ack,
   output logic            wb_rty,
   output logic            wb_err,
   input  logic [N_CH-1:0] m_cyc,
   input  logic [N_CH-1:0] m_stb,
   input  logic [N_CH-1:0] m_ack
);

   bus_state_e       state_q;
   logic             ack_q;
   logic [31:0]      rdat_q, rdat;
   logic [N_CH-1:0]  en_q, en_d, ovf_q, ovf_d, ovf_set;
   logic [11:0]      adr_w;
   logic             ch_region, access, wr_stb, clr;
   logic [3:0]       ch_idx, ch_off;
   logic             unused_bus;

   logic [CNT_W-1:0] ch_time   [N_CH];
   logic [CNT_W-1:0] ch_ack    [N_CH];
   logic [LAT_W-1:0] ch_maxlat [N_CH];
   logic [LAT_W-1:0] ch_lastlat[N_CH];

   assign adr_w      = {wb_adr[11:2], 2'b00};
   assign ch_region  = (adr_w[11:8] == CHAN_PAGE);
   assign ch_idx     = adr_w[CHAN_IDX_LSB +: 4];
   assign ch_off     = adr_w[CHAN_IDX_LSB-1:0];
   assign access     = wb_cyc & wb_stb & (state_q == S_IDLE);
   assign wr_stb     = access & wb_we;
   assign clr        = wr_stb & (adr_w == OFF_CTRL) & wb_dat_o[CTRL_CLR_BIT];
   assign unused_bus = ^{wb_sel, wb_adr[31:12], wb_adr[1:0]};

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic sel;
      assign sel = wr_stb & ch_region & (ch_idx == 4'(g));
      perf_chan #(.CNT_W(CNT_W), .LAT_W(LAT_W)) u_chan (
         .clk        (clk),
         .rst        (rst),
         .en_i       (en_q[g]),
         .clr_i      (clr),
         .m_cyc_i    (m_cyc[g]),
         .m_stb_i    (m_stb[g]),
         .m_ack_i    (m_ack[g]),
         .wr_time_i  (sel & (ch_off == CH_TIME)),
         .wr_ack_i   (sel & (ch_off == CH_ACK)),
         .wr_maxlat_i(sel & (ch_off == CH_MAXLAT)),
         .wdat_i     (wb_dat_o),
         .time_o     (ch_time[g]),
         .ack_o      (ch_ack[g]),
         .maxlat_o   (ch_maxlat[g]),
         .lastlat_o  (ch_lastlat[g]),
         .ovf_set_o  (ovf_set[g])
      );
   end

   // Fresh overflow events beat a same-cycle write-1-to-clear; CLR beats both.
   always_comb begin
      en_d  = en_q;
      ovf_d = ovf_q;
      if (wr_stb && adr_w == OFF_CTRL) en_d = wb_dat_o[N_CH-1:0];
      if (clr) begin
         ovf_d = '0;
      end else begin
         if (wr_stb && adr_w == OFF_STATUS) ovf_d = ovf_q & ~wb_dat_o[N_CH-1:0];
         ovf_d = ovf_d | ovf_set;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q  <= '1;
         ovf_q <= '0;
      end else begin
         en_q  <= en_d;
         ovf_q <= ovf_d;
      end
   end

   always_comb begin
      rdat = '0;
      if (adr_w == OFF_CTRL) begin
         rdat[N_CH-1:0] = en_q;
      end else if (adr_w == OFF_STATUS) begin
         rdat[N_CH-1:0] = ovf_q;
      end else if (adr_w == OFF_ID) begin
         rdat = {ID_MAGIC, 8'(N_CH), 8'(CNT_W), 8'(LAT_W)};
      end else if (ch_region) begin
         for (int i = 0; i < N_CH; i++) begin
            if (ch_idx == 4'(i)) begin
               case (ch_off)
                  CH_TIME:    rdat[CNT_W-1:0] = ch_time[i];
                  CH_ACK:     rdat[CNT_W-1:0] = ch_ack[i];
                  CH_MAXLAT:  rdat[LAT_W-1:0] = ch_maxlat[i];
                  CH_LASTLAT: rdat[LAT_W-1:0] = ch_lastlat[i];
                  default:    rdat = '0;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ack_q   <= 1'b0;
         rdat_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (wb_cyc && wb_stb) begin
                  state_q <= S_ACK;
                  ack_q   <= 1'b1;
                  rdat_q  <= wb_we ? 32'h0 : rdat;
               end
            end
            S_ACK: begin
               state_q <= S_IDLE;
               ack_q   <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

   assign wb_ack   = ack_q;
   assign wb_dat_i = rdat_q;
   assign wb_rty   = 1'b0;
   assign wb_err   = 1'b0;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: bus accesses queue their expected
// read data, a negedge monitor pops and compares on every wb_ack.
module tb_perf_counter_bank;

   localparam int N_CH = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [31:0]     wb_adr = '0;
   logic [31:0]     wb_dat_o = '0;
   logic [31:0]     wb_dat_i;
   logic            wb_we = 1'b0;
   logic            wb_stb = 1'b0;
   logic            wb_cyc = 1'b0;
   logic [3:0]      wb_sel = 4'hF;
   logic            wb_ack, wb_rty, wb_err;
   logic [N_CH-1:0] m_cyc = '0;
   logic [N_CH-1:0] m_stb = '0;
   logic [N_CH-1:0] m_ack = '0;

   int checks = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   bit          chk_q[$];
   string       tag_q[$];

   logic [31:0] mon_exp;
   bit          mon_chk;
   string       mon_tag;

   perf_counter_bank #(.N_CH(N_CH), .CNT_W(32), .LAT_W(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .wb_adr  (wb_adr),
      .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i),
      .wb_we   (wb_we),
      .wb_stb  (wb_stb),
      .wb_cyc  (wb_cyc),
      .wb_sel  (wb_sel),
      .wb_ack  (wb_ack),
      .wb_rty  (wb_rty),
      .wb_err  (wb_err),
      .m_cyc   (m_cyc),
      .m_stb   (m_stb),
      .m_ack   (m_ack)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wb_ack && !rst) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack dat=%h", wb_dat_i);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_chk = chk_q.pop_front();
            mon_tag = tag_q.pop_front();
            if (mon_chk) begin
               checks++;
               if (wb_dat_i !== mon_exp) begin
                  failures++;
                  $display("FAIL %s got=%h want=%h", mon_tag, wb_dat_i, mon_exp);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_now(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic bus_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [31:0] exp, input bit chk, input string tag);
      int n;
      exp_q.push_back(exp);
      chk_q.push_back(chk);
      tag_q.push_back(tag);
      wb_adr = adr; wb_we = we; wb_dat_o = wdat; wb_cyc = 1'b1; wb_stb = 1'b1;
      n = 0;
      @(posedge clk); #1;
      while (!wb_ack && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      if (!wb_ack) begin
         checks++;
         failures++;
         $display("FAIL %s ack_timeout got=0 want=1", tag);
         void'(exp_q.pop_back());
         void'(chk_q.pop_back());
         void'(tag_q.pop_back());
      end
   endtask

   task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string tag);
      bus_xfer(adr, 1'b0, 32'h0, exp, 1'b1, tag);
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
      bus_xfer(adr, 1'b1, dat, 32'h0, 1'b0, "wr");
   endtask

   task automatic m_access(input logic [N_CH-1:0] mask, input int waits);
      m_cyc = mask; m_stb = mask; m_ack = '0;
      tick(waits);
      m_ack = mask;
      tick(1);
      m_cyc = '0; m_stb = '0; m_ack = '0;
   endtask

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog got=running want=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      tick(3);
      check_now("rst_ack", {31'h0, wb_ack}, 32'h0);
      check_now("rst_dat", wb_dat_i, 32'h0);
      rst = 1'b0;
      tick(1);

      // Defaults and ID
      rd(32'h008, 32'h5004_2010, "id");
      rd(32'h000, 32'h0000_000F, "ctrl_rst");
      rd(32'h004, 32'h0, "status_rst");
      for (int c = 0; c < N_CH; c++)
         for (int r = 0; r < 4; r++)
            rd(32'(32'h100 + c * 16 + r * 4), 32'h0, "ch_rst");

      // Back-to-back: ack every second cycle
      tick(1);
      exp_q.push_back(32'h5004_2010); chk_q.push_back(1'b1); tag_q.push_back("b2b_0");
      exp_q.push_back(32'h5004_2010); chk_q.push_back(1'b1); tag_q.push_back("b2b_1");
      wb_adr = 32'h008; wb_cyc = 1'b1; wb_stb = 1'b1;
      tick(4);
      wb_cyc = 1'b0; wb_stb = 1'b0;

      // Ch1 two 4-cycle accesses, then a 2-cycle one; ch3 zero-wait
      m_access(4'b0010, 3);
      m_access(4'b0010, 3);
      rd(32'h110, 32'd8, "ch1_time");
      rd(32'h114, 32'd2, "ch1_ack");
      rd(32'h118, 32'd4, "ch1_max");
      rd(32'h11C, 32'd4, "ch1_last");
      m_access(4'b0010, 1);
      rd(32'h110, 32'd10, "ch1_time2");
      rd(32'h118, 32'd4, "ch1_max_keep");
      rd(32'h11C, 32'd2, "ch1_last2");
      m_access(4'b1000, 0);
      rd(32'h13C, 32'd1, "ch3_zero_wait");

      // Ch1 disabled while ch0 runs
      wr(32'h000, 32'h0000_000D);
      rd(32'h000, 32'h0000_000D, "ctrl_d");
      for (int k = 0; k < 10; k++) m_access(4'b0011, 2);
      rd(32'h110, 32'd10, "ch1_hold_time");
      rd(32'h114, 32'd3, "ch1_hold_ack");
      rd(32'h100, 32'd30, "ch0_time");
      rd(32'h104, 32'd10, "ch0_ack");
      rd(32'h108, 32'd3, "ch0_max");
      wr(32'h000, 32'h0000_000F);

      // Saturation and sticky overflow
      wr(32'h100, 32'hFFFF_FFFE);
      m_cyc = 4'b0001; m_stb = 4'b0001;
      tick(3);
      m_cyc = '0; m_stb = '0;
      tick(1);
      rd(32'h100, 32'hFFFF_FFFF, "ch0_sat");
      rd(32'h004, 32'h1, "ovf_set");
      rd(32'h10C, 32'd3, "ch0_last_noack");
      wr(32'h004, 32'h1);
      rd(32'h004, 32'h0, "ovf_w1c");

      // CLR on the same edge as a ch2 ack
      m_access(4'b0100, 2);
      rd(32'h124, 32'd1, "ch2_ack_pre");
      m_cyc = 4'b0001; m_stb = 4'b0001;
      tick(1);
      m_cyc = '0; m_stb = '0;
      rd(32'h004, 32'h1, "ovf_pre_clr");
      m_cyc = 4'b0100; m_stb = 4'b0100; m_ack = 4'b0100;
      wr(32'h000, 32'h8000_000F);
      m_cyc = '0; m_stb = '0; m_ack = '0;
      rd(32'h124, 32'h0, "clr_ch2_ack");
      rd(32'h128, 32'h0, "clr_ch2_max");
      rd(32'h120, 32'h0, "clr_ch2_time");
      rd(32'h004, 32'h0, "clr_status");
      rd(32'h100, 32'h0, "clr_ch0_time");
      rd(32'h000, 32'h0000_000F, "ctrl_after_clr");

      // Unmapped and out-of-range channel
      wr(32'h150, 32'h1234_5678);
      rd(32'h150, 32'h0, "ch5_read");
      rd(32'h00C, 32'h0, "unmapped_00c");

      // Reset in the middle of an access
      tick(1);
      wb_adr = 32'h008; wb_cyc = 1'b1; wb_stb = 1'b1;
      @(posedge clk); #1;
      check_now("ack_before_rst", {31'h0, wb_ack}, 32'h1);
      rst = 1'b1;
      #1;
      check_now("ack_on_rst", {31'h0, wb_ack}, 32'h0);
      check_now("dat_on_rst", wb_dat_i, 32'h0);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      exp_q.delete(); chk_q.delete(); tag_q.delete();
      tick(2);
      rst = 1'b0;
      tick(3);
      check_now("no_stale_ack", {31'h0, wb_ack}, 32'h0);
      rd(32'h000, 32'h0000_000F, "ctrl_post_rst");
      rd(32'h114, 32'h0, "ch1_ack_post_rst");

      tick(2);
      check_now("queue_drain", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
